// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - shared AHB encodings and burst-length helper for the bus-matrix arbiter
package ahb_mtx_pkg;

  // HTRANS encodings
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HBURST encodings
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Remaining-beat counter width; 15 is the largest load value.
  localparam int CNT_W = 4;

  // Beats still to come after the NONSEQ of a burst; 0 for SINGLE and undefined-length INCR.
  function automatic logic [CNT_W-1:0] burst_count(input logic [2:0] burst);
    case (burst)
      HBURST_INCR4,  HBURST_WRAP4:  return CNT_W'(3);
      HBURST_INCR8,  HBURST_WRAP8:  return CNT_W'(7);
      HBURST_INCR16, HBURST_WRAP16: return CNT_W'(15);
      default:                      return '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mtx_rr_picker.sv
// rtl/ahb_mtx_rr_picker.sv - combinational round-robin select starting after the last winner
module ahb_mtx_rr_picker #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req_vec,
  input  logic [PORT_W-1:0]    last,
  output logic [PORT_W-1:0]    winner,
  output logic                 valid
);

  // First requester above last wins; otherwise wrap and take the first at or below last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!valid && req_vec[j] && (j > int'(last))) begin
        valid  = 1'b1;
        winner = PORT_W'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!valid && req_vec[j] && (j <= int'(last))) begin
        valid  = 1'b1;
        winner = PORT_W'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_mtx_out_arb.sv
// rtl/ahb_mtx_out_arb.sv - AHB matrix output-stage arbiter (AHB_MTX_ARB_FIXED_PRIO_EN selects fixed priority)
module ahb_mtx_out_arb
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_vec,
  input  logic                 HREADYM,
  input  logic [1:0]           trans_op,
  input  logic [2:0]           burst_op,
  input  logic                 mastlock_op,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic [PORT_W-1:0]    data_in_port,
  output logic [NUM_PORTS-1:0] active_vec
);

  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              hold_grant;
  logic [PORT_W-1:0] last_port;
  logic [PORT_W-1:0] pick_idx;
  logic              pick_valid;

  ahb_mtx_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_picker (
    .req_vec (req_vec),
    .last    (last_port),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

`ifdef AHB_MTX_ARB_FIXED_PRIO_EN
  // Searching from "after the top port" makes the picker lowest-index-wins.
  assign last_port = PORT_W'(NUM_PORTS - 1);
`else
  // Remember the last winner so the next search starts just after it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_port <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM && !hold_grant && pick_valid) begin
      last_port <= pick_idx;
    end
  end
`endif

  // Beat count after the transfer currently in its address phase is accepted.
  always_comb begin
    cnt_nxt = beat_cnt;
    if (!no_port) begin
      case (trans_op)
        HTRANS_NONSEQ: cnt_nxt = burst_count(burst_op);
        HTRANS_SEQ:    if (beat_cnt != '0) cnt_nxt = beat_cnt - CNT_W'(1);
        HTRANS_BUSY:   cnt_nxt = beat_cnt;
        default:       cnt_nxt = '0;
      endcase
    end
  end

  // The count is judged after this edge so the NONSEQ opening a fixed burst already holds,
  // and an IDLE or SINGLE NONSEQ that ends a burst early releases the grant at once.
  assign hold_grant = (cnt_nxt != '0) ||
                      (!no_port && (mastlock_op ||
                                    trans_op == HTRANS_BUSY ||
                                    trans_op == HTRANS_SEQ));

  // Grant, data-phase select and burst count advance only while the output is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      data_in_port <= '0;
      beat_cnt     <= '0;
    end else if (HREADYM) begin
      beat_cnt     <= cnt_nxt;
      data_in_port <= addr_in_port;
      if (!hold_grant) begin
        if (pick_valid) begin
          addr_in_port <= pick_idx;
          no_port      <= 1'b0;
        end else begin
          no_port      <= 1'b1;
        end
      end
    end
  end

  // One-hot owner of the address phase, empty while no port is granted.
  always_comb begin
    active_vec = '0;
    if (!no_port) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (addr_in_port == PORT_W'(j)) active_vec[j] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mtx_out_arb.sv
// tb/tb_ahb_mtx_out_arb.sv - scoreboard bench for the AHB matrix output arbiter
module tb_ahb_mtx_out_arb;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SGL  = 3'b000;
  localparam logic [2:0] B_I4   = 3'b011;
  localparam logic [2:0] B_I8   = 3'b101;
  localparam logic [2:0] B_I16  = 3'b111;

  logic       HCLK;
  logic       HRESETn;
  logic [2:0] req_vec;
  logic       HREADYM;
  logic [1:0] trans_op;
  logic [2:0] burst_op;
  logic       mastlock_op;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [1:0] data_in_port;
  logic [2:0] active_vec;

  typedef struct {
    int         id;
    logic [1:0] a;
    logic       np;
    logic [1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  ahb_mtx_out_arb #(.NUM_PORTS(3), .PORT_W(2)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_vec      (req_vec),
    .HREADYM      (HREADYM),
    .trans_op     (trans_op),
    .burst_op     (burst_op),
    .mastlock_op  (mastlock_op),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .data_in_port (data_in_port),
    .active_vec   (active_vec)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string name, input int id, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, id, got, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] a, input logic np);
    logic [2:0] v;
    v = np ? 3'b000 : (3'b001 << a);
    return v;
  endfunction

  // Drive one cycle of input-stage activity and queue the outputs expected after its edge.
  task automatic step(input logic rst, input logic [2:0] req, input logic hr,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                      input logic [1:0] ea, input logic enp, input logic [1:0] ed);
    exp_t e;
    @(negedge HCLK);
    HRESETn     = rst;
    req_vec     = req;
    HREADYM     = hr;
    trans_op    = tr;
    burst_op    = bu;
    mastlock_op = lk;
    e.id = step_id;
    e.a  = ea;
    e.np = enp;
    e.d  = ed;
    sb.push_back(e);
    step_id++;
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("addr_in_port", e.id, int'(addr_in_port), int'(e.a));
        chk("no_port",      e.id, int'(no_port),      int'(e.np));
        chk("data_in_port", e.id, int'(data_in_port), int'(e.d));
        chk("active_vec",   e.id, int'(active_vec),   int'(onehot(e.a, e.np)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout expected=finish", step_id);
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; req_vec = '0; HREADYM = 1'b1;
    trans_op = T_IDLE; burst_op = B_SGL; mastlock_op = 1'b0;
    //    rst req     hr tr      bu     lk   a  np d
    step(0, 3'b000, 1, T_IDLE, B_SGL, 0,   0, 1, 0);
    // round robin over SINGLEs, with one stall
    step(1, 3'b111, 1, T_IDLE, B_SGL, 0,   0, 0, 0);
    step(1, 3'b111, 1, T_NS,   B_SGL, 0,   1, 0, 0);
    step(1, 3'b111, 1, T_NS,   B_SGL, 0,   2, 0, 1);
    step(1, 3'b111, 0, T_NS,   B_SGL, 0,   2, 0, 1);
    step(1, 3'b111, 1, T_NS,   B_SGL, 0,   0, 0, 2);
    step(1, 3'b111, 1, T_NS,   B_SGL, 0,   1, 0, 0);
    step(1, 3'b000, 1, T_NS,   B_SGL, 0,   1, 1, 1);
    // port 1 INCR4 while 0 and 2 wait
    step(1, 3'b010, 1, T_IDLE, B_SGL, 0,   1, 0, 1);
    step(1, 3'b111, 1, T_NS,   B_I4,  0,   1, 0, 1);
    step(1, 3'b111, 1, T_SEQ,  B_I4,  0,   1, 0, 1);
    step(1, 3'b111, 1, T_SEQ,  B_I4,  0,   1, 0, 1);
    step(1, 3'b111, 1, T_SEQ,  B_I4,  0,   1, 0, 1);
    step(1, 3'b101, 1, T_IDLE, B_I4,  0,   2, 0, 1);
    // port 0 INCR4 with two wait states and a BUSY beat
    step(1, 3'b111, 1, T_NS,   B_SGL, 0,   0, 0, 2);
    step(1, 3'b011, 1, T_NS,   B_I4,  0,   0, 0, 0);
    step(1, 3'b011, 1, T_SEQ,  B_I4,  0,   0, 0, 0);
    step(1, 3'b011, 0, T_SEQ,  B_I4,  0,   0, 0, 0);
    step(1, 3'b011, 0, T_SEQ,  B_I4,  0,   0, 0, 0);
    step(1, 3'b011, 1, T_BUSY, B_I4,  0,   0, 0, 0);
    step(1, 3'b011, 1, T_SEQ,  B_I4,  0,   0, 0, 0);
    step(1, 3'b011, 1, T_SEQ,  B_I4,  0,   0, 0, 0);
    step(1, 3'b010, 1, T_IDLE, B_I4,  0,   1, 0, 0);
    // port 2 locked pair of SINGLEs
    step(1, 3'b111, 1, T_NS,   B_SGL, 0,   2, 0, 1);
    step(1, 3'b111, 1, T_NS,   B_SGL, 1,   2, 0, 2);
    step(1, 3'b111, 1, T_NS,   B_SGL, 1,   2, 0, 2);
    step(1, 3'b011, 0, T_IDLE, B_SGL, 0,   2, 0, 2);
    step(1, 3'b011, 1, T_IDLE, B_SGL, 0,   0, 0, 2);
    // port 0 INCR8 cut short by IDLE after three beats
    step(1, 3'b011, 1, T_NS,   B_I8,  0,   0, 0, 0);
    step(1, 3'b011, 1, T_SEQ,  B_I8,  0,   0, 0, 0);
    step(1, 3'b011, 1, T_SEQ,  B_I8,  0,   0, 0, 0);
    step(1, 3'b010, 1, T_IDLE, B_I8,  0,   1, 0, 0);
    // reset in the middle of port 1 INCR16
    step(1, 3'b010, 1, T_NS,   B_I16, 0,   1, 0, 1);
    step(1, 3'b010, 1, T_SEQ,  B_I16, 0,   1, 0, 1);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("async_no_port",    step_id, int'(no_port),      1);
    chk("async_active_vec", step_id, int'(active_vec),   0);
    chk("async_addr",       step_id, int'(addr_in_port), 0);
    chk("async_data",       step_id, int'(data_in_port), 0);
    step(0, 3'b010, 1, T_SEQ,  B_I16, 0,   0, 1, 0);
    step(1, 3'b100, 1, T_IDLE, B_SGL, 0,   2, 0, 0);
    step(1, 3'b100, 1, T_NS,   B_SGL, 0,   2, 0, 2);
    step(1, 3'b000, 1, T_NS,   B_SGL, 0,   2, 1, 2);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge HCLK);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_out_arb.md
Name: ahb_mtx_out_arb

Overview:
- Output-stage arbiter for the AHB bus matrix.
- Shares one output port (MI0 slave interface) between NUM_PORTS input stages.
- Uses round-robin selection, holding the grant for the full length of defined bursts and for locked sequences.
- Drives the output-stage address/data mux selects and the per-port active indications consumed by each input port's decoder.

Parameters:
- NUM_PORTS, 3, number of input stages competing for this output port (2..8).
- PORT_W, 2, width of port index; must satisfy 2**PORT_W >= NUM_PORTS.

Ports:
- HCLK  input  1  AHB system clock
- HRESETn  input  1  asynchronous active-low reset
- req_vec  input  NUM_PORTS  per-port request: decoder sel to this output AND input-stage trans != IDLE
- HREADYM  input  1  HREADY of the output port; arbitration and data-phase update occur only when high
- trans_op  input  2  HTRANS of the currently addressed port (muxed by addr_in_port)
- burst_op  input  3  HBURST of the currently addressed port
- mastlock_op  input  1  HMASTLOCK of the currently addressed port
- addr_in_port  output  PORT_W  address-phase mux select
- no_port  output  1  high when no port owns the address phase (output drives IDLE)
- data_in_port  output  PORT_W  data-phase mux select, registered
- active_vec  output  NUM_PORTS  one-hot; bit n high when port n owns the address phase and no_port is low

Behaviour:
- Reset values: addr_in_port=0, data_in_port=0, no_port=1, active_vec=0, burst counter=0, last-grant pointer=NUM_PORTS-1 (so port 0 has first priority).
- Arbitration point: a rising HCLK edge with HREADYM=1 and hold_grant=0. At that edge, addr_in_port/no_port update from the picker.
- HREADYM=0: all arbiter state is frozen.
- Picker (round-robin): searches from (last+1) mod NUM_PORTS upward with wrap; the first set req_vec bit wins. last is updated to the winner.
- No requests: no_port=1; addr_in_port keeps its previous value.
- hold_grant=1 when any of the following holds:
  - (a) burst counter != 0;
  - (b) mastlock_op=1 and no_port=0;
  - (c) trans_op is BUSY or SEQ (undefined-length INCR continuation).
- Burst counter:
  - Loaded on accepted NONSEQ (HREADYM=1, trans_op=NONSEQ): INCR4/WRAP4 -> 3, INCR8/WRAP8 -> 7, INCR16/WRAP16 -> 15, SINGLE/INCR -> 0.
  - Decremented by 1 on each accepted SEQ.
  - Unchanged on BUSY.
- Early burst termination: an accepted IDLE, or an accepted NONSEQ while the counter is non-zero, means the counter is cleared (or reloaded for the new NONSEQ). The grant is then re-evaluated normally.
- Requester drops while granted (req bit low, no hold): re-arbitrate at the next HREADYM-high edge.
- data_in_port: <= addr_in_port on every HREADYM-high edge; single-cycle latency from address to data phase.
- active_vec is combinational from addr_in_port/no_port. A port is never both granted and absent from active_vec.
- Reset mid-burst: all state returns to reset values asynchronously, with no residual hold.

Optional Feature:
- Macro: AHB_MTX_ARB_FIXED_PRIO_EN.
- Defined: the picker is fixed priority, lowest index wins. The last-grant pointer is not implemented. Burst and lock hold rules are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package ahb_mtx_pkg holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HBURST encodings;
  - the burst-length-to-count function.
- One natural sub-module: ahb_mtx_rr_picker, a combinational rotate/priority-select taking req_vec and last and returning winner index and valid.
- Counter and hold logic stay in the top.

Test Plan:
- Reset, then req_vec=3'b111 with SINGLE NONSEQs and HREADYM=1 every cycle -> grants 0,1,2,0,… with addr_in_port advancing each cycle; data_in_port lags by one cycle.
- Port 1 issues INCR4 (NONSEQ+3 SEQ) while ports 0 and 2 request -> addr_in_port=1 for 4 accepted beats, then port 2 is granted.
- INCR4 from port 0 with HREADYM low for 2 cycles mid-burst plus one BUSY beat -> counter and grant frozen; grant is held until the 4th beat is accepted.
- Port 2 asserts mastlock_op across two SINGLE transfers while ports 0 and 1 request -> grant stays 2 until mastlock_op drops and HREADYM=1.
- Port 0 INCR8 is terminated early by IDLE after 3 beats, with port 1 requesting -> port 1 is granted at the next HREADYM-high edge.
- HRESETn pulsed low mid-INCR16 -> immediately no_port=1, active_vec=0, counter=0. After release with req_vec=3'b100 -> port 2 is granted on the first edge.
- With AHB_MTX_ARB_FIXED_PRIO_EN, req_vec=3'b111 with SINGLEs -> port 0 is granted every cycle.
